// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: DE/HS/VS, pixel coordinates, SOF and frame count.
// Optional VTG_SHADOW_EN: timing inputs latched at frame boundaries instead of used live.
module video_timing_gen #(
    parameter int CW  = 12,
    parameter int FCW = 8
) (
    input  logic           I_clk,
    input  logic           I_rst_n,
    input  logic           I_en,
    input  logic [CW-1:0]  I_h_total,
    input  logic [CW-1:0]  I_h_sync,
    input  logic [CW-1:0]  I_h_bporch,
    input  logic [CW-1:0]  I_h_res,
    input  logic [CW-1:0]  I_v_total,
    input  logic [CW-1:0]  I_v_sync,
    input  logic [CW-1:0]  I_v_bporch,
    input  logic [CW-1:0]  I_v_res,
    input  logic           I_hs_pol,
    input  logic           I_vs_pol,
    output logic           O_de,
    output logic           O_hs,
    output logic           O_vs,
    output logic [CW-1:0]  O_x,
    output logic [CW-1:0]  O_y,
    output logic           O_sof,
    output logic [FCW-1:0] O_frame_cnt,
    output logic           O_cfg_err
);
    localparam int SW = CW + 2;

    logic [CW-1:0] a_h_total, a_h_sync, a_h_bporch, a_h_res;
    logic [CW-1:0] a_v_total, a_v_sync, a_v_bporch, a_v_res;
    logic          a_hs_pol, a_vs_pol;

    logic [CW-1:0] h_q, v_q, h_d, v_d;
    logic          cfg_err, run, h_last, v_last, frame_last;
    logic [SW-1:0] h_start, h_end, v_start, v_end, h_ext, v_ext;
    logic          h_act, v_act, hsync, vsync, sof_d;

`ifdef VTG_SHADOW_EN
    logic [CW-1:0] sh_h_total_q, sh_h_sync_q, sh_h_bporch_q, sh_h_res_q;
    logic [CW-1:0] sh_v_total_q, sh_v_sync_q, sh_v_bporch_q, sh_v_res_q;
    logic          sh_hs_pol_q, sh_vs_pol_q;
    logic          capture;

    assign capture = frame_last | ~I_en | cfg_err;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sh_h_total_q  <= '0;
            sh_h_sync_q   <= '0;
            sh_h_bporch_q <= '0;
            sh_h_res_q    <= '0;
            sh_v_total_q  <= '0;
            sh_v_sync_q   <= '0;
            sh_v_bporch_q <= '0;
            sh_v_res_q    <= '0;
            sh_hs_pol_q   <= 1'b0;
            sh_vs_pol_q   <= 1'b0;
        end else if (capture) begin
            sh_h_total_q  <= I_h_total;
            sh_h_sync_q   <= I_h_sync;
            sh_h_bporch_q <= I_h_bporch;
            sh_h_res_q    <= I_h_res;
            sh_v_total_q  <= I_v_total;
            sh_v_sync_q   <= I_v_sync;
            sh_v_bporch_q <= I_v_bporch;
            sh_v_res_q    <= I_v_res;
            sh_hs_pol_q   <= I_hs_pol;
            sh_vs_pol_q   <= I_vs_pol;
        end
    end

    assign a_h_total  = sh_h_total_q;
    assign a_h_sync   = sh_h_sync_q;
    assign a_h_bporch = sh_h_bporch_q;
    assign a_h_res    = sh_h_res_q;
    assign a_v_total  = sh_v_total_q;
    assign a_v_sync   = sh_v_sync_q;
    assign a_v_bporch = sh_v_bporch_q;
    assign a_v_res    = sh_v_res_q;
    assign a_hs_pol   = sh_hs_pol_q;
    assign a_vs_pol   = sh_vs_pol_q;
`else
    assign a_h_total  = I_h_total;
    assign a_h_sync   = I_h_sync;
    assign a_h_bporch = I_h_bporch;
    assign a_h_res    = I_h_res;
    assign a_v_total  = I_v_total;
    assign a_v_sync   = I_v_sync;
    assign a_v_bporch = I_v_bporch;
    assign a_v_res    = I_v_res;
    assign a_hs_pol   = I_hs_pol;
    assign a_vs_pol   = I_vs_pol;
`endif

    // Widened sums so large settings cannot alias into a legal-looking total.
    assign h_start = {2'b00, a_h_sync} + {2'b00, a_h_bporch};
    assign v_start = {2'b00, a_v_sync} + {2'b00, a_v_bporch};
    assign h_end   = h_start + {2'b00, a_h_res};
    assign v_end   = v_start + {2'b00, a_v_res};
    assign h_ext   = {2'b00, h_q};
    assign v_ext   = {2'b00, v_q};

    assign cfg_err = (h_end > {2'b00, a_h_total}) | (v_end > {2'b00, a_v_total})
                   | (a_h_res == '0) | (a_v_res == '0)
                   | (a_h_sync == '0) | (a_v_sync == '0);
    assign run     = I_en & ~cfg_err;

    // >= rather than == so a counter stranded past a shrunken total wraps at once.
    assign h_last     = h_q >= a_h_total - 1'b1;
    assign v_last     = v_q >= a_v_total - 1'b1;
    assign frame_last = (h_q == a_h_total - 1'b1) & (v_q == a_v_total - 1'b1);

    assign h_act = (h_ext >= h_start) & (h_ext < h_end);
    assign v_act = (v_ext >= v_start) & (v_ext < v_end);
    assign hsync = h_q < a_h_sync;
    assign vsync = v_q < a_v_sync;
    assign sof_d = run & (h_q == '0) & (v_q == '0);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (cfg_err) begin
            h_d = '0;
            v_d = '0;
        end else if (I_en) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
                if (v_q >= a_v_total) v_d = '0;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_q         <= '0;
            v_q         <= '0;
            O_de        <= 1'b0;
            O_hs        <= 1'b0;
            O_vs        <= 1'b0;
            O_x         <= '0;
            O_y         <= '0;
            O_sof       <= 1'b0;
            O_frame_cnt <= '0;
            O_cfg_err   <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            O_de        <= run & h_act & v_act;
            O_hs        <= run ? (hsync ~^ a_hs_pol) : ~a_hs_pol;
            O_vs        <= run ? (vsync ~^ a_vs_pol) : ~a_vs_pol;
            O_x         <= (run & h_act & v_act) ? h_q - h_start[CW-1:0] : '0;
            O_y         <= (run & h_act & v_act) ? v_q - v_start[CW-1:0] : '0;
            O_sof       <= sof_d;
            O_frame_cnt <= O_frame_cnt + FCW'(sof_d);
            O_cfg_err   <= cfg_err;
        end
    end
endmodule
